// File: rtl/vowel_pkg.sv
// Shared definitions for the vowel RAM controller: FSM state encoding and the
// ASCII codes of the ten vowel characters.
package vowel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LC_A = 8'h61;
  localparam logic [7:0] LC_E = 8'h65;
  localparam logic [7:0] LC_I = 8'h69;
  localparam logic [7:0] LC_O = 8'h6F;
  localparam logic [7:0] LC_U = 8'h75;
  localparam logic [7:0] UC_A = 8'h41;
  localparam logic [7:0] UC_E = 8'h45;
  localparam logic [7:0] UC_I = 8'h49;
  localparam logic [7:0] UC_O = 8'h4F;
  localparam logic [7:0] UC_U = 8'h55;

endpackage

// File: rtl/vowel_detect.sv
// Combinational vowel classifier for one character.
// Build option: VOWEL_UPPERCASE_EN -- when defined, A E I O U count as vowels
// too; otherwise only lowercase a e i o u are recognised.
// Ports:
//   ch        in  DATA_W  character to classify
//   is_vowel  out 1       character is a vowel
module vowel_detect
  import vowel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ch,
  output logic              is_vowel
);

  // Match the character against the vowel table.
  always_comb begin
    is_vowel = 1'b0;
    case (ch)
      DATA_W'(LC_A), DATA_W'(LC_E), DATA_W'(LC_I),
      DATA_W'(LC_O), DATA_W'(LC_U): is_vowel = 1'b1;
`ifdef VOWEL_UPPERCASE_EN
      DATA_W'(UC_A), DATA_W'(UC_E), DATA_W'(UC_I),
      DATA_W'(UC_O), DATA_W'(UC_U): is_vowel = 1'b1;
`endif
      default: is_vowel = 1'b0;
    endcase
  end

endmodule

// File: rtl/vowel_ram_ctrl.sv
// Controller for a 64x8 vowel RAM (sync write, async read) in the password
// checker. Loads a password over a valid/ready port, scans the stored string
// one character per cycle, counts vowels and flags pass/fail.
// Build option: VOWEL_UPPERCASE_EN (see vowel_detect) selects case-insensitive
// vowel matching.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready   character input handshake
//   ram_w_en/ram_addr/ram_w_data        RAM write / address
//   ram_r_data            RAM async read data at ram_addr
//   done                  one-cycle pulse, results valid
//   vowel_count, length, pass, overflow  results, held until the next load
module vowel_ram_ctrl
  import vowel_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int MIN_VOWELS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              done,
  output logic [ADDR_W:0]   vowel_count,
  output logic [ADDR_W:0]   length,
  output logic              pass,
  output logic              overflow
);

  localparam int              CNT_W    = ADDR_W + 1;
  // Pointer value of the final RAM slot; an accept there closes the load.
  localparam logic [CNT_W-1:0] FULL_PTR = CNT_W'((1 << ADDR_W) - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_VOWELS);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             take_last;
  logic             scan_end;
  logic             is_vowel;

  vowel_detect #(.DATA_W(DATA_W)) u_detect (
    .ch       (ram_r_data),
    .is_vowel (is_vowel)
  );

  assign count_next = vowel_count + CNT_W'(is_vowel);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and RAM/handshake outputs decoded from the current state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    take_last  = 1'b0;
    scan_end   = 1'b0;
    ram_w_en   = 1'b0;
    ram_addr   = '0;
    ram_w_data = in_data;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        ram_w_en  = accept;
        take_last = accept & in_last;
        if (take_last) begin
          state_next = SCAN;
        end else if (accept) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        ram_w_en  = accept;
        ram_addr  = wr_ptr[ADDR_W-1:0];
        // Filling the last slot ends the load even without in_last.
        take_last = accept & (in_last | (wr_ptr == FULL_PTR));
        if (take_last) begin
          state_next = SCAN;
        end else begin
          state_next = LOAD;
        end
      end
      SCAN: begin
        ram_addr = rd_ptr[ADDR_W-1:0];
        scan_end = (rd_ptr == (length - CNT_W'(1)));
        if (scan_end) begin
          state_next = DONE;
        end else begin
          state_next = SCAN;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pointers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      vowel_count <= '0;
      length      <= '0;
      pass        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // New password: drop the previous results.
            wr_ptr      <= CNT_W'(1);
            rd_ptr      <= '0;
            vowel_count <= '0;
            pass        <= 1'b0;
            overflow    <= 1'b0;
            length      <= take_last ? CNT_W'(1) : '0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + CNT_W'(1);
          end
          if (take_last) begin
            length   <= wr_ptr + CNT_W'(1);
            overflow <= ~in_last;
            rd_ptr   <= '0;
          end
        end
        SCAN: begin
          vowel_count <= count_next;
          rd_ptr      <= rd_ptr + CNT_W'(1);
          if (scan_end) begin
            pass <= (count_next >= MIN_CNT);
          end
        end
        DONE: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        default: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vowel_ram_ctrl.sv
// Self-checking bench for vowel_ram_ctrl with a behavioural 64x8 RAM and a
// scoreboard of expected results keyed to the done pulse.
module tb_vowel_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       ram_w_en;
  logic [5:0] ram_addr;
  logic [7:0] ram_w_data;
  logic [7:0] ram_r_data;
  logic       done;
  logic [6:0] vowel_count;
  logic [6:0] length;
  logic       pass;
  logic       overflow;

  logic [7:0] mem [64];

  typedef struct {
    int len;
    int cnt;
    int ps;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;
  int   last_acc = 0;

  vowel_ram_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .ram_w_en    (ram_w_en),
    .ram_addr    (ram_addr),
    .ram_w_data  (ram_w_data),
    .ram_r_data  (ram_r_data),
    .done        (done),
    .vowel_count (vowel_count),
    .length      (length),
    .pass        (pass),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_w_data;
  end
  assign ram_r_data = mem[ram_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int is_v(input byte c);
    if (c == "a" || c == "e" || c == "i" || c == "o" || c == "u") return 1;
`ifdef VOWEL_UPPERCASE_EN
    if (c == "A" || c == "E" || c == "I" || c == "O" || c == "U") return 1;
`endif
    return 0;
  endfunction

  // Monitor: track the last accept and score each done pulse.
  always @(negedge clk) begin
    ncyc++;
    if (in_valid && in_ready) last_acc = ncyc;
    if (done) begin
      if (sb.size() == 0) begin
        check_val("done_unexpected", 1, 0);
      end else begin
        last_exp = sb.pop_front();
        check_val("length", length, last_exp.len);
        check_val("vowel_count", vowel_count, last_exp.cnt);
        check_val("pass", pass, last_exp.ps);
        check_val("overflow", overflow, last_exp.ovf);
        check_val("latency", ncyc - last_acc, last_exp.len + 1);
      end
    end
  end

  // Drive one character; entered just after a posedge, returns just after the accepting posedge.
  task automatic drive_char(input byte c, input bit last);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = c;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) check_val("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s, input bit last_on_end, input bit gaps,
                      input bit push, input bit hold_valid);
    exp_t e;
    int   n = s.len();
    e.len = (n > 64) ? 64 : n;
    e.cnt = 0;
    for (int i = 0; i < e.len; i++) e.cnt += is_v(s[i]);
    e.ps  = (e.cnt >= 2) ? 1 : 0;
    e.ovf = (n == 64 && !last_on_end) ? 1 : 0;
    if (push) sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = "x";
        @(negedge clk);
        check_val("gap_no_write", ram_w_en, 0);
        @(posedge clk);
        #1;
      end
      drive_char(s[i], last_on_end && (i == n - 1));
    end
    if (hold_valid) begin
      in_valid = 1'b1;
      in_data  = "z";
      in_last  = 1'b0;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    @(negedge clk);
    check_val("ready_drop", in_ready, 0);
  endtask

  // Wait (bounded) for done, then confirm results are held into IDLE.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_val("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("held_count", vowel_count, last_exp.cnt);
    check_val("done_pulse_width", done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s64;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    #2;
    check_val("rst_ready", in_ready, 1);
    check_val("rst_done", done, 0);
    check_val("rst_wen", ram_w_en, 0);
    check_val("rst_addr", ram_addr, 0);
    check_val("rst_count", vowel_count, 0);
    check_val("rst_len", length, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("abc", 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done();
    check_val("mem0_abc", mem[0], "a");
    check_val("mem2_abc", mem[2], "c");

    send("aeiou", 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done();

    s64 = "";
    for (int i = 0; i < 64; i++) s64 = {s64, "a"};
    send(s64, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();

    // Keep in_valid high through SCAN/DONE: nothing may be taken or written.
    send("AEb", 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check_val("ign_ready", in_ready, 0);
      check_val("ign_wen", ram_w_en, 0);
      if (done) break;
      @(negedge clk);
    end
    check_val("ign_done_seen", done, 1);
    wait_done();
    check_val("mem0_AEb", mem[0], "A");
    check_val("mem1_AEb", mem[1], "E");
    check_val("mem2_AEb", mem[2], "b");
    check_val("mem3_kept", mem[3], "a");

    // Abort mid-scan with reset.
    send("aaaaaaaaaa", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_count", vowel_count, 0);
    check_val("abort_len", length, 0);
    check_val("abort_pass", pass, 0);
    check_val("abort_ovf", overflow, 0);
    check_val("abort_done", done, 0);
    check_val("abort_wen", ram_w_en, 0);
    check_val("abort_addr", ram_addr, 0);
    check_val("abort_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_val("post_abort_no_done", done, 0);
    end
    @(posedge clk);
    #1;

    send("oo", 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done();
    check_val("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
